// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// The datapath uses the master modport and the controller uses the slave modport.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_uses_rs2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rd;
  logic             EX_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_freeze;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs2, ID_EX_MemRead, ID_EX_rd,
           EX_branch_taken, dmem_req, dmem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze,
           mem_timeout_err, stall_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs2, ID_EX_MemRead, ID_EX_rd,
           EX_branch_taken, dmem_req, dmem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze,
           mem_timeout_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: memory-wait freeze with timeout, branch flush, load-use bubble,
// and a saturating count of cycles in which the PC was held.
//   state    | meaning
//   RUN      | no outstanding data-memory access
//   MEM_WAIT | access pending, pipeline frozen until dmem_ready
//   ERROR    | access exceeded TIMEOUT cycles; frozen until reset
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, state_nx;
  logic [WC_W-1:0]   wait_cnt, wait_nx;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  logic              load_use;
  logic              mem_stall;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      err      <= err | (state_nx == ERROR);
      if (!pc_write && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    case (state)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_nx = MEM_WAIT;
          wait_nx  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_nx = RUN;
          wait_nx  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERROR;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      ERROR:   state_nx = ERROR;
      default: begin
        state_nx = RUN;
        wait_nx  = '0;
      end
    endcase
  end

  always_comb begin
    load_use = bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
               ((bus.ID_EX_rd == bus.ID_rs1) ||
                (bus.ID_uses_rs2 && (bus.ID_EX_rd == bus.ID_rs2)));
    mem_stall = ((state == RUN) && bus.dmem_req && !bus.dmem_ready) ||
                ((state == MEM_WAIT) && !bus.dmem_ready) ||
                (state == ERROR);

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    // Upstream inputs are frozen during a stall, so branch/load-use simply re-evaluate afterwards.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze     = 1'b1;
    end else if (bus.EX_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign bus.PC_write        = pc_write;
  assign bus.IF_ID_write     = ifid_write;
  assign bus.IF_ID_flush     = ifid_flush;
  assign bus.ID_EX_flush     = idex_flush;
  assign bus.pipe_freeze     = freeze;
  assign bus.mem_timeout_err = err;
  assign bus.stall_count     = cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (TIMEOUT=4, CNT_W=4): vector table
// for single-cycle hazard decode, hand sequences for memory wait, timeout and reset.
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze}
  localparam logic [4:0] O_NORM   = 5'b11000;
  localparam logic [4:0] O_LU     = 5'b00010;
  localparam logic [4:0] O_BR     = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RST    = 5'b00110;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       memread;
    logic [4:0] ex_rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] exp_out;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [4:0] outs();
    return {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_flush, bus.pipe_freeze};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
    bus.ID_rs1          = rs1;
    bus.ID_rs2          = rs2;
    bus.ID_uses_rs2     = uses;
    bus.ID_EX_MemRead   = mr;
    bus.ID_EX_rd        = rd;
    bus.EX_branch_taken = br;
    bus.dmem_req        = req;
    bus.dmem_ready      = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             rs1    rs2    use   mr    rd     br    req   rdy   expected
    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[1] = '{5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[3] = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[4] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[5] = '{5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[6] = '{5'd2, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7] = '{5'd2, 5'd3, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, O_NORM};
    vecs[8] = '{5'd5, 5'd3, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[9] = '{5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, O_LU};

    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_outs", 32'(outs()), 32'(O_RST));
    chk("reset_err", 32'(bus.mem_timeout_err), 32'd0);
    chk("reset_cnt", 32'(bus.stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rs2, vecs[i].memread,
             vecs[i].ex_rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.stall_count), 32'(exp_cnt));
      if (vecs[i].exp_out[4] == 1'b0 && exp_cnt < 15) exp_cnt++;
    end

    // Memory wait of three cycles with a pending branch and load-use held behind it.
    next_cycle();
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("wait1_outs", 32'(outs()), 32'(O_FREEZE));
    chk("wait1_cnt", 32'(bus.stall_count), 32'(exp_cnt));
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      bus.dmem_req = 1'b0;
      @(negedge clk);
      chk($sformatf("wait%0d_outs", c), 32'(outs()), 32'(O_FREEZE));
    end
    next_cycle();
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk("wait_ready_outs", 32'(outs()), 32'(O_BR));
    exp_cnt += 3;
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wait_after_outs", 32'(outs()), 32'(O_NORM));
    chk("wait_after_cnt", 32'(bus.stall_count), 32'(exp_cnt));
    chk("wait_after_err", 32'(bus.mem_timeout_err), 32'd0);

    // Timeout: four frozen cycles, then ERROR with sticky flag, then saturation.
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("to%0d_outs", c), 32'(outs()), 32'(O_FREEZE));
      chk($sformatf("to%0d_err", c), 32'(bus.mem_timeout_err), 32'd0);
      next_cycle();
    end
    bus.dmem_req   = 1'b0;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk("err_flag", 32'(bus.mem_timeout_err), 32'd1);
    chk("err_outs", 32'(outs()), 32'(O_FREEZE));
    repeat (20) next_cycle();
    @(negedge clk);
    chk("err_sticky", 32'(bus.mem_timeout_err), 32'd1);
    chk("cnt_saturate", 32'(bus.stall_count), 32'd15);

    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("err_rst_outs", 32'(outs()), 32'(O_RST));
    chk("err_rst_err", 32'(bus.mem_timeout_err), 32'd0);
    chk("err_rst_cnt", 32'(bus.stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("post_err_outs", 32'(outs()), 32'(O_NORM));
    chk("post_err_cnt", 32'(bus.stall_count), 32'd0);

    // Reset in the middle of MEM_WAIT abandons the access.
    next_cycle();
    bus.dmem_req = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("mw_outs", 32'(outs()), 32'(O_FREEZE));
    chk("mw_cnt", 32'(bus.stall_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mw_rst_outs", 32'(outs()), 32'(O_RST));
    chk("mw_rst_cnt", 32'(bus.stall_count), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.dmem_req = 1'b0;
    @(negedge clk);
    chk("mw_post_outs", 32'(outs()), 32'(O_NORM));
    next_cycle();
    @(negedge clk);
    chk("mw_post_cnt", 32'(bus.stall_count), 32'd0);
    chk("mw_post_err", 32'(bus.mem_timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning maximum consecutive MEM_WAIT cycles before error; legal range 2..255.
REQ-002 Parameter CNT_W, default 16, meaning width of stall_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ID_rs1  input  5  rs1 of instruction in ID.
REQ-006 ID_rs2  input  5  rs2 of instruction in ID.
REQ-007 ID_uses_rs2  input  1  ID instruction reads rs2.
REQ-008 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-009 ID_EX_rd  input  5  rd of instruction in EX.
REQ-010 EX_branch_taken  input  1  branch/jump in EX redirects PC this cycle.
REQ-011 dmem_req  input  1  MEM stage issues a data-memory access this cycle.
REQ-012 dmem_ready  input  1  data memory completes the access this cycle.
REQ-013 PC_write  output  1  PC register update enable.
REQ-014 IF_ID_write  output  1  IF/ID register update enable.
REQ-015 IF_ID_flush  output  1  IF/ID loads a bubble.
REQ-016 ID_EX_flush  output  1  ID/EX loads a bubble.
REQ-017 pipe_freeze  output  1  hold EX/MEM, MEM/WB and all earlier registers.
REQ-018 mem_timeout_err  output  1  sticky memory-timeout error flag.
REQ-019 stall_count  output  CNT_W  saturating count of cycles with PC_write=0.

Function
REQ-020 States SHALL be RUN, MEM_WAIT, ERROR; one state register plus a wait counter of ceil(log2(TIMEOUT)) bits.
REQ-021 load_use SHALL be ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==ID_rs1 || (ID_uses_rs2 && ID_EX_rd==ID_rs2)).
REQ-022 mem_stall SHALL be (RUN && dmem_req && !dmem_ready) || (MEM_WAIT && !dmem_ready) || ERROR.
REQ-023 Priority, combinational, same cycle: mem_stall > EX_branch_taken > load_use > normal.
REQ-024 mem_stall: pipe_freeze=1, PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=0.
REQ-025 Branch (no mem_stall): PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1, pipe_freeze=0.
REQ-026 Load-use (no mem_stall, no branch): PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0, pipe_freeze=0; exactly one bubble per load-use since EX advances.
REQ-027 Normal: PC_write=1, IF_ID_write=1, flushes=0, pipe_freeze=0.
REQ-028 RUN -> MEM_WAIT when dmem_req && !dmem_ready; wait counter loads 1.
REQ-029 MEM_WAIT -> RUN when dmem_ready (pipe_freeze drops that same cycle); counter clears.
REQ-030 MEM_WAIT, !dmem_ready, counter==TIMEOUT-1 -> ERROR; else counter increments.
REQ-031 ERROR SHALL be terminal until reset; mem_timeout_err=1 registered, asserted from first ERROR cycle.
REQ-032 dmem_req deassertion while in MEM_WAIT SHALL be ignored; only dmem_ready exits.
REQ-033 Branch or load_use coincident with mem_stall SHALL be held, re-evaluated on first non-stall cycle (inputs are frozen upstream).
REQ-034 stall_count SHALL increment by 1 on each cycle PC_write=0, saturating at 2^CNT_W-1, never wrapping.

Reset
REQ-035 rst_n low SHALL asynchronously force state=RUN, wait counter=0, mem_timeout_err=0, stall_count=0.
REQ-036 While rst_n low, outputs SHALL be PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, pipe_freeze=0.
REQ-037 Reset asserted mid MEM_WAIT or ERROR SHALL abandon the access; first cycle after release is RUN with normal outputs.

Verification
REQ-038 Load x5 in EX, ID add x6,x5,x7 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_count 0->1; with ID_EX_rd=0 no stall.
REQ-039 ID_uses_rs2=0, ID_rs2=ID_EX_rd=5, load -> no stall; ID_uses_rs2=1 -> stall.
REQ-040 EX_branch_taken=1 with load_use=1 -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1.
REQ-041 dmem_req=1, dmem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, 0 on ready cycle, state RUN next; stall_count +3.
REQ-042 TIMEOUT=4, dmem_ready never -> ERROR after 4 frozen cycles, mem_timeout_err=1 sticky; rst_n pulse clears err and count.
REQ-043 CNT_W=4, 20 continuous stall cycles -> stall_count holds 15.
